// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target endpoint.
package spi_target_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WRITE,
      READ,
      SKIP
   } state_t;

   localparam int CMD_RW_BIT = 7;
   localparam int BYTE_BITS  = 8;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one SPI pin, with optional single-cycle
// rise/fall pulses taken from the synchronized level.
module spi_pin_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0,
   parameter logic EDGE_EN     = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pin_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= {SYNC_STAGES{RESET_VAL}};
      else       sync_q <= sync_d;
   end

   assign q_o = sync_q[SYNC_STAGES-1];

   generate
      if (EDGE_EN) begin : g_edge
         logic prev_q;
         logic prev_d;

         always_comb begin
            prev_d = q_o;
         end

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) prev_q <= RESET_VAL;
            else       prev_q <= prev_d;
         end

         assign rise_o = q_o & ~prev_q;
         assign fall_o = ~q_o & prev_q;
      end else begin : g_no_edge
         assign rise_o = 1'b0;
         assign fall_o = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: command/address byte, then auto-incrementing burst
// access to a byte register file that is shared with a local host port.
module spi_target
   import spi_target_pkg::*;
#(
   parameter int         NUM_REGS    = 16,
   parameter logic [7:0] ID_BYTE     = 8'hA5,
   parameter int         SYNC_STAGES = 2,
   localparam int        AW          = $clog2(NUM_REGS)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          spi_clk_i,
   input  logic          spi_mosi_i,
   input  logic          spi_csn_i,
   output logic          spi_miso_o,
   output logic          spi_miso_oe_o,
   input  logic [AW-1:0] host_addr_i,
   input  logic          host_we_i,
   input  logic [7:0]    host_wdata_i,
   output logic [7:0]    host_rdata_o,
   output logic          wr_valid_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [7:0]    wr_data_o,
   output logic          addr_err_o,
   output logic          frame_done_o
);

   localparam int CNT_W = $clog2(BYTE_BITS);

   logic sclk_rise, sclk_fall, csn_rise, csn_fall, mosi_s;
   logic sclk_lvl_unused, csn_lvl_unused, mosi_rise_unused, mosi_fall_unused;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b1)) u_sclk_sync (
      .clk_i(clk_i), .rst_i(rst_i), .pin_i(spi_clk_i),
      .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGE_EN(1'b1)) u_csn_sync (
      .clk_i(clk_i), .rst_i(rst_i), .pin_i(spi_csn_i),
      .q_o(csn_lvl_unused), .rise_o(csn_rise), .fall_o(csn_fall)
   );

   // MOSI goes through the same depth as SCLK so a detected rise sees the matching bit.
   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b0)) u_mosi_sync (
      .clk_i(clk_i), .rst_i(rst_i), .pin_i(spi_mosi_i),
      .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
   );

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [BYTE_BITS-1:0]   rx_q, rx_d;
   logic [BYTE_BITS-1:0]   tx_q, tx_d;
   logic [AW-1:0]          ptr_q, ptr_d;
   logic                   oe_q, oe_d;
   logic                   load_q, load_d;
   logic                   wr_valid_q, wr_valid_d;
   logic [AW-1:0]          wr_addr_q, wr_addr_d;
   logic [7:0]             wr_data_q, wr_data_d;
   logic                   addr_err_q, addr_err_d;
   logic                   frame_done_q, frame_done_d;
   logic [7:0]             host_rdata_q, host_rdata_d;
   logic [7:0]             regs_q [NUM_REGS];
   logic [7:0]             regs_d [NUM_REGS];

   logic [BYTE_BITS-1:0]   rx_byte;
   logic [6:0]             cmd_addr;
   logic                   spi_we;

   assign rx_byte  = {rx_q[BYTE_BITS-2:0], mosi_s};
   assign cmd_addr = rx_byte[6:0];

   // NOTE: every signal gets a default first so no path through the if/case tree infers a latch.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      rx_d         = rx_q;
      tx_d         = tx_q;
      ptr_d        = ptr_q;
      oe_d         = oe_q;
      load_d       = 1'b0;
      spi_we       = 1'b0;
      wr_valid_d   = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      addr_err_d   = 1'b0;
      frame_done_d = 1'b0;

      if (state_q == IDLE) begin
         if (csn_fall) begin
            state_d   = CMD;
            bit_cnt_d = '0;
            oe_d      = 1'b1;
            tx_d      = ID_BYTE;
         end
      end else if (csn_rise) begin
         state_d      = IDLE;
         bit_cnt_d    = '0;
         oe_d         = 1'b0;
         tx_d         = '0;
         frame_done_d = 1'b1;
      end else begin
         if (load_q) begin
            tx_d  = regs_q[ptr_q];
            ptr_d = ptr_q + AW'(1);
         end
         // bit_cnt==0 means a fresh byte already presents its MSB; do not shift it away.
         if (sclk_fall && bit_cnt_q != '0) begin
            tx_d = {tx_q[BYTE_BITS-2:0], 1'b0};
         end
         if (sclk_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(BYTE_BITS - 1)) begin
               case (state_q)
                  CMD: begin
                     tx_d = '0;
                     if ({1'b0, cmd_addr} >= 8'(NUM_REGS)) begin
                        addr_err_d = 1'b1;
                        state_d    = SKIP;
                     end else begin
                        ptr_d   = cmd_addr[AW-1:0];
                        state_d = rx_byte[CMD_RW_BIT] ? READ : WRITE;
                        load_d  = rx_byte[CMD_RW_BIT];
                     end
                  end
                  WRITE: begin
                     spi_we     = 1'b1;
                     wr_valid_d = 1'b1;
                     wr_addr_d  = ptr_q;
                     wr_data_d  = rx_byte;
                     ptr_d      = ptr_q + AW'(1);
                  end
                  READ:    load_d = 1'b1;
                  default: ;
               endcase
            end
         end
      end
   end

   // SPI commit is applied last so it overrides a host write to the same byte.
   always_comb begin
      regs_d = regs_q;
      if (host_we_i) regs_d[host_addr_i] = host_wdata_i;
      if (spi_we)    regs_d[ptr_q]       = rx_byte;
      host_rdata_d = regs_d[host_addr_i];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         rx_q         <= '0;
         tx_q         <= '0;
         ptr_q        <= '0;
         oe_q         <= 1'b0;
         load_q       <= 1'b0;
         wr_valid_q   <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         addr_err_q   <= 1'b0;
         frame_done_q <= 1'b0;
         host_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         rx_q         <= rx_d;
         tx_q         <= tx_d;
         ptr_q        <= ptr_d;
         oe_q         <= oe_d;
         load_q       <= load_d;
         wr_valid_q   <= wr_valid_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         addr_err_q   <= addr_err_d;
         frame_done_q <= frame_done_d;
         host_rdata_q <= host_rdata_d;
      end
   end

   // NOTE: the register file must read 0x00 after reset, so it is built from resettable flops, not RAM.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   assign spi_miso_o    = tx_q[BYTE_BITS-1];
   assign spi_miso_oe_o = oe_q;
   assign host_rdata_o  = host_rdata_q;
   assign wr_valid_o    = wr_valid_q;
   assign wr_addr_o     = wr_addr_q;
   assign wr_data_o     = wr_data_q;
   assign addr_err_o    = addr_err_q;
   assign frame_done_o  = frame_done_q;

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI target (slave) endpoint for the SPI controller's external pins. It is the device at the far end of spi_clk/spi_mosi/spi_csn, and it drives spi_miso.
- Oversamples the SPI pins in the system clock domain, decodes a command/address byte, and then streams data bytes into or out of a small byte-wide register file with address auto-increment.
- A local host port gives SoC-side read/write access to the same register file.

Parameters:
- NUM_REGS, 16, register file depth in bytes; power of 2, 2..128.
- ID_BYTE, 8'hA5, byte shifted out on MISO during the command byte.
- SYNC_STAGES, 2, synchronizer depth for the SPI input pins; minimum 2.

Ports:
- clk_i  input  1  system clock; must be at least 8x the SPI clock frequency.
- rst_i  input  1  reset, asynchronous, active-high.
- spi_clk_i  input  1  SPI clock (mode 0: CPOL=0, CPHA=0).
- spi_mosi_i  input  1  controller-out, target-in serial data.
- spi_csn_i  input  1  chip select, active low.
- spi_miso_o  output  1  target-out serial data.
- spi_miso_oe_o  output  1  MISO output enable; high while selected.
- host_addr_i  input  $clog2(NUM_REGS)  host register address.
- host_we_i  input  1  host write strobe.
- host_wdata_i  input  8  host write data.
- host_rdata_o  output  8  registered read data for host_addr_i; 1-cycle latency.
- wr_valid_o  output  1  1-cycle pulse when an SPI write commits a byte.
- wr_addr_o  output  $clog2(NUM_REGS)  address of the committed byte.
- wr_data_o  output  8  data of the committed byte.
- addr_err_o  output  1  1-cycle pulse when a command addresses a location >= NUM_REGS.
- frame_done_o  output  1  1-cycle pulse on CSN deassertion.

Behaviour:
- Reset:
  - All outputs 0; register file cleared to 0x00; state IDLE.
  - Reset asserted mid-frame aborts the frame immediately. No commit occurs.
- Pin synchronization:
  - spi_clk_i, spi_csn_i and spi_mosi_i pass through SYNC_STAGES flops.
  - Edge detection adds 1 cycle, so a pin edge is acted on SYNC_STAGES+1 clk_i cycles after it occurs.
- Bit order and timing:
  - MSB first, 8-bit bytes.
  - MOSI is sampled on detected SCLK rising edges.
  - MISO is updated on detected SCLK falling edges.
- States: IDLE, CMD, WRITE, READ, SKIP.
- IDLE:
  - On a detected CSN fall: go to CMD; bit_cnt=0; spi_miso_oe_o=1; load the TX shift register with ID_BYTE; spi_miso_o=ID_BYTE[7].
- CMD, on completion of the 8th bit:
  - cmd[7]=1 means read, 0 means write; cmd[6:0] is the start address.
  - If cmd[6:0] >= NUM_REGS: pulse addr_err_o and go to SKIP. Writes are discarded; MISO drives 0 for the rest of the frame.
  - Else, write command: go to WRITE with ptr=cmd addr.
  - Else, read command: go to READ; load the TX shift register with regs[ptr] in the cycle after the 8th rising edge; spi_miso_o = regs[ptr][7] before the next SCLK rise; ptr increments.
- WRITE, each completed byte:
  - regs[ptr] <= byte.
  - Pulse wr_valid_o with wr_addr_o=ptr and wr_data_o=byte, 1 cycle after the 8th rising edge is detected.
  - ptr <= ptr+1, wrapping from NUM_REGS-1 to 0.
- READ, each completed byte:
  - Load the TX shift register with regs[ptr], then ptr++ with wrap.
  - MOSI data is ignored.
- SKIP: ignores all bytes until CSN rises.
- CSN rise in any non-IDLE state:
  - Discard the partial byte (no commit, no wr_valid_o).
  - Pulse frame_done_o; spi_miso_oe_o=0; spi_miso_o=0; go to IDLE.
  - CSN rise takes priority over an SCLK edge detected in the same cycle.
- Host port:
  - Write takes effect next cycle.
  - SPI commit and host write to the same address in the same cycle: the SPI commit wins and the host write is dropped.
  - host_rdata_o reflects the register contents after that cycle's writes.
- SCLK edges while CSN is high are ignored.

Decomposition:
- spi_target_pkg holds:
  - state_t enum {IDLE, CMD, WRITE, READ, SKIP}.
  - Constants CMD_RW_BIT=7 and BYTE_BITS=8.
- Sub-module spi_pin_sync: parameterized synchronizer with rise/fall pulse outputs. Instantiated for spi_clk_i and spi_csn_i; a no-edge variant is used for MOSI.

Test Plan:
- Write burst:
  - Stimulus: CSN low; send 0x02, 0x11, 0x22; CSN high.
  - Expect: wr_valid_o pulses (addr 2, 0x11) then (addr 3, 0x22); frame_done_o pulses once; host read of addr 2 returns 0x11 and addr 3 returns 0x22.
- Read burst:
  - Stimulus: host writes regs[5]=0x3C and regs[6]=0xC3; SPI sends 0x85, 0x00, 0x00.
  - Expect: MISO bytes 0xA5, 0x3C, 0xC3; spi_miso_oe_o high only while CSN is low.
- Address wrap:
  - Stimulus: write command 0x0F, then data 0xAA, 0xBB, 0xCC.
  - Expect: regs[15]=0xAA, regs[0]=0xBB, regs[1]=0xCC.
- Out of range:
  - Stimulus: command 0x20 then data 0x55; then a second frame with command 0xA0 and one dummy byte.
  - Expect: one addr_err_o pulse per frame; no wr_valid_o; registers unchanged; second frame's MISO bytes are 0xA5, 0x00.
- Abort:
  - Stimulus: write frame 0x04; CSN rises after 5 data bits.
  - Expect: no wr_valid_o; regs[4] unchanged; frame_done_o pulses; next full write to addr 4 of 0x77 succeeds.
- Reset:
  - Stimulus: rst_i asserted mid-read at 200 MHz clk_i / 10 MHz SCLK.
  - Expect: all outputs 0 within the same cycle; all registers read 0x00 afterwards.
  - Simultaneity: SPI commit and host write to addr 3 in the same cycle leave the SPI value.
